// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus for regfile_wb_arbiter: three producer request channels,
// issue-side reservation and hazard lookup, and the RegFile write port.
// The master modport is the producer/issue/RegFile side, slave is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          req0, req1, req2;
  logic [AW-1:0] reg0, reg1, reg2;
  logic [DW-1:0] dat0, dat1, dat2;
  logic          gnt0, gnt1, gnt2;
  logic          rsv;
  logic [AW-1:0] rsvReg;
  logic [AW-1:0] qA, qB;
  logic          hazA, hazB;
  logic          RegWrite;
  logic [AW-1:0] regW;
  logic [DW-1:0] Wdat;

  modport master (
    output req0, req1, req2, reg0, reg1, reg2, dat0, dat1, dat2,
    output rsv, rsvReg, qA, qB,
    input  gnt0, gnt1, gnt2, hazA, hazB, RegWrite, regW, Wdat
  );

  modport slave (
    input  req0, req1, req2, reg0, reg1, reg2, dat0, dat1, dat2,
    input  rsv, rsvReg, qA, qB,
    output gnt0, gnt1, gnt2, hazA, hazB, RegWrite, regW, Wdat
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy-register scoreboard for the register file's
// single write port. One producer is granted per cycle; the winning write
// is registered onto RegWrite/regW/Wdat for RegFile.
// Optional feature: define REGFILE_WB_RR_EN for round-robin arbitration;
// without it the arbiter uses fixed priority ALU > MEM > MDU.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 1 << AW;

  logic [2:0]      req;
  logic [2:0]      gnt;
  logic [AW-1:0]   win_reg;
  logic [DW-1:0]   win_dat;
  logic            reg_write;
  logic [AW-1:0]   reg_w;
  logic [DW-1:0]   wdat;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  assign req = {bus.req2, bus.req1, bus.req0};

`ifdef REGFILE_WB_RR_EN
  logic [1:0] ptr;

  // Round-robin pick: search starts at ptr and wraps over the three requesters
  always_comb begin
    gnt = 3'b000;
    if (rst) begin
      case (ptr)
        2'd1: begin
          if (req[1])      gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
        end
        2'd2: begin
          if (req[2])      gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
        end
        default: begin
          if (req[0])      gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  // Pointer moves just past the winner; it stays put on idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 2'd0;
    end else if (gnt[0]) begin
      ptr <= 2'd1;
    end else if (gnt[1]) begin
      ptr <= 2'd2;
    end else if (gnt[2]) begin
      ptr <= 2'd0;
    end
  end
`else
  // Fixed priority pick, ALU first and MDU last; grants are gated off in reset
  always_comb begin
    gnt = 3'b000;
    if (rst) begin
      if (req[0])      gnt = 3'b001;
      else if (req[1]) gnt = 3'b010;
      else if (req[2]) gnt = 3'b100;
    end
  end
`endif

  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];
  assign bus.gnt2 = gnt[2];

  // Select the destination and data of whichever requester won this cycle
  always_comb begin
    win_reg = '0;
    win_dat = '0;
    if (gnt[0]) begin
      win_reg = bus.reg0;
      win_dat = bus.dat0;
    end else if (gnt[1]) begin
      win_reg = bus.reg1;
      win_dat = bus.dat1;
    end else if (gnt[2]) begin
      win_reg = bus.reg2;
      win_dat = bus.dat2;
    end
  end

  // Register the granted write; register 0 is consumed but never enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write <= 1'b0;
      reg_w     <= '0;
      wdat      <= '0;
    end else if (|gnt) begin
      reg_write <= (win_reg != '0);
      reg_w     <= win_reg;
      wdat      <= win_dat;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Next busy vector: a grant clears its target, then a reservation sets,
  // so a same-edge reservation of the granted register keeps it busy
  always_comb begin
    busy_next = busy;
    if (|gnt) begin
      busy_next[win_reg] = 1'b0;
    end
    if (bus.rsv && (bus.rsvReg != '0)) begin
      busy_next[bus.rsvReg] = 1'b1;
    end
  end

  // Scoreboard state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign bus.RegWrite = reg_write;
  assign bus.regW     = reg_w;
  assign bus.Wdat     = wdat;

  // The RegWrite term covers the cycle before RegFile commits the write
  assign bus.hazA = (bus.qA != '0) && (busy[bus.qA] || (reg_write && (reg_w == bus.qA)));
  assign bus.hazB = (bus.qB != '0) && (busy[bus.qB] || (reg_write && (reg_w == bus.qB)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. A driver issues directed and random
// traffic and pushes expected grants, hazards and write-backs from a
// reference model; a monitor pops and compares at each falling edge.
// Build with REGFILE_WB_RR_EN defined to check the round-robin variant.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    bit            we;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  int  gntQ[$];
  bit [1:0] hazQ[$];
  wb_t wbQ[$];
  bit  monEn = 1'b0;

  // Reference model state: which registers have a producer in flight,
  // the write RegFile is about to commit, and the round-robin start point
  bit            mBusy[32];
  bit            lastWe;
  logic [AW-1:0] lastReg;
  int            mPtr;

  // Per-requester pending transaction used by the random phase
  bit            pend[3];
  logic [AW-1:0] pReg[3];
  logic [DW-1:0] pDat[3];

  regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pickGrant(input bit [2:0] r);
    int k;
`ifdef REGFILE_WB_RR_EN
    for (int i = 0; i < 3; i++) begin
      k = (mPtr + i) % 3;
      if (r[k]) return k;
    end
`else
    for (k = 0; k < 3; k++) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  function automatic bit modelHaz(input logic [AW-1:0] q);
    return (q != 0) && (mBusy[q] || (lastWe && lastReg == q));
  endfunction

  task automatic resetModel();
    foreach (mBusy[i]) mBusy[i] = 1'b0;
    lastWe  = 1'b0;
    lastReg = '0;
    mPtr    = 0;
    foreach (pend[i]) pend[i] = 1'b0;
    gntQ.delete();
    hazQ.delete();
    wbQ.delete();
  endtask

  // Copy the pending-transaction table onto the request lines
  task automatic applyStimulus();
    bus.req0 = pend[0]; bus.reg0 = pReg[0]; bus.dat0 = pDat[0];
    bus.req1 = pend[1]; bus.reg1 = pReg[1]; bus.dat1 = pDat[1];
    bus.req2 = pend[2]; bus.reg2 = pReg[2]; bus.dat2 = pDat[2];
  endtask

  // Called at posedge+1 with inputs settled: predict this cycle, advance the
  // model across the coming edge, and return at the next posedge+1
  task automatic stepCycle(output int k);
    bit [2:0]      r;
    logic [AW-1:0] regs[3];
    logic [DW-1:0] dats[3];
    wb_t           w;
    #1;
    r = {bus.req2, bus.req1, bus.req0};
    regs[0] = bus.reg0; regs[1] = bus.reg1; regs[2] = bus.reg2;
    dats[0] = bus.dat0; dats[1] = bus.dat1; dats[2] = bus.dat2;
    k = pickGrant(r);
    gntQ.push_back(k);
    hazQ.push_back({modelHaz(bus.qB), modelHaz(bus.qA)});
    if (k >= 0) begin
      w.we = (regs[k] != 0);
      w.r  = regs[k];
      w.d  = dats[k];
      wbQ.push_back(w);
      mBusy[regs[k]] = 1'b0;
      lastWe  = (regs[k] != 0);
      lastReg = regs[k];
      mPtr    = (k + 1) % 3;
    end else begin
      lastWe = 1'b0;
    end
    if (bus.rsv && bus.rsvReg != 0) mBusy[bus.rsvReg] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare grants and hazards every cycle, and the registered
  // write port in the cycle after each observed grant
  initial begin
    int  e;
    bit [1:0] h;
    wb_t w;
    bit  prevG;
    prevG = 1'b0;
    forever begin
      @(negedge clk);
      if (!monEn) begin
        prevG = 1'b0;
      end else begin
        if (prevG) begin
          if (wbQ.size() > 0) begin
            w = wbQ.pop_front();
            checkOutput("wb_we",  bus.RegWrite, w.we);
            checkOutput("wb_reg", bus.regW,     w.r);
            checkOutput("wb_dat", bus.Wdat,     w.d);
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL wb_unexpected actual=grant_seen required=no_grant");
          end
        end else begin
          checkOutput("wb_idle_we", bus.RegWrite, 1'b0);
        end
        if (gntQ.size() > 0) begin
          e = gntQ.pop_front();
          h = hazQ.pop_front();
          checkOutput("gnt", {bus.gnt2, bus.gnt1, bus.gnt0}, (e < 0) ? 3'b000 : (3'b001 << e));
          checkOutput("haz", {bus.hazB, bus.hazA}, h);
        end
        prevG = bus.gnt0 | bus.gnt1 | bus.gnt2;
      end
    end
  end

  // Bound the whole run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized phase
  initial begin
    int k;
    bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
    bus.reg0 = 0; bus.reg1 = 0; bus.reg2 = 0;
    bus.dat0 = 0; bus.dat1 = 0; bus.dat2 = 0;
    bus.rsv = 0; bus.rsvReg = 0; bus.qA = 0; bus.qB = 0;
    foreach (pReg[i]) begin pReg[i] = '0; pDat[i] = '0; end
    resetModel();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_regwrite", bus.RegWrite, 1'b0);
    checkOutput("rst_regw",     bus.regW,     '0);
    checkOutput("rst_wdat",     bus.Wdat,     '0);
    rst = 1'b1;
    monEn = 1'b1;

    $display("[TB] single write");
    bus.req0 = 1; bus.reg0 = 7; bus.dat0 = 32'hDEADBEEF;
    stepCycle(k);
    bus.req0 = 0;
    stepCycle(k);
    stepCycle(k);

    $display("[TB] three-way contention");
    bus.req0 = 1; bus.reg0 = 1; bus.dat0 = 32'h11;
    bus.req1 = 1; bus.reg1 = 2; bus.dat1 = 32'h22;
    bus.req2 = 1; bus.reg2 = 3; bus.dat2 = 32'h33;
    repeat (6) stepCycle(k);
    bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
    stepCycle(k);

    $display("[TB] scoreboard");
    bus.qA = 9; bus.qB = 4;
    bus.rsv = 1; bus.rsvReg = 9;
    stepCycle(k);
    bus.rsv = 0;
    stepCycle(k);
    bus.req1 = 1; bus.reg1 = 9; bus.dat1 = 32'h0000_0999;
    stepCycle(k);
    bus.req1 = 0;
    stepCycle(k);
    stepCycle(k);
    bus.rsv = 1; bus.rsvReg = 9;
    bus.req1 = 1; bus.reg1 = 9; bus.dat1 = 32'h0000_0A0A;
    stepCycle(k);
    bus.rsv = 0; bus.req1 = 0;
    stepCycle(k);
    stepCycle(k);
    bus.req0 = 1; bus.reg0 = 9; bus.dat0 = 32'h0000_0B0B;
    stepCycle(k);
    bus.req0 = 0;
    stepCycle(k);
    stepCycle(k);

    $display("[TB] register zero");
    bus.req2 = 1; bus.reg2 = 0; bus.dat2 = 32'h1;
    stepCycle(k);
    bus.req2 = 0;
    bus.rsv = 1; bus.rsvReg = 0; bus.qA = 0;
    stepCycle(k);
    bus.rsv = 0;
    stepCycle(k);

    $display("[TB] reset mid-transfer");
    bus.rsv = 1; bus.rsvReg = 5;
    bus.req0 = 1; bus.reg0 = 3; bus.dat0 = 32'h55;
    stepCycle(k);
    bus.rsv = 0; bus.req0 = 0;
    bus.req1 = 1; bus.reg1 = 12; bus.dat1 = 32'hA5A5_5A5A;
    bus.qA = 5; bus.qB = 3;
    monEn = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_regwrite", bus.RegWrite, 1'b0);
    checkOutput("arst_regw",     bus.regW,     '0);
    checkOutput("arst_wdat",     bus.Wdat,     '0);
    checkOutput("arst_gnt",      {bus.gnt2, bus.gnt1, bus.gnt0}, 3'b000);
    checkOutput("arst_haz",      {bus.hazB, bus.hazA}, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("arst_hold_gnt", {bus.gnt2, bus.gnt1, bus.gnt0}, 3'b000);
    checkOutput("arst_hold_haz", {bus.hazB, bus.hazA}, 2'b00);
    resetModel();
    rst = 1'b1;
    monEn = 1'b1;
    stepCycle(k);
    bus.req1 = 0;
    stepCycle(k);
    stepCycle(k);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pReg[i] = AW'($urandom_range(0, 15));
          pDat[i] = $urandom;
        end
      end
      applyStimulus();
      bus.rsv    = ($urandom_range(0, 3) == 0);
      bus.rsvReg = AW'($urandom_range(0, 15));
      bus.qA     = AW'($urandom_range(0, 15));
      bus.qB     = AW'($urandom_range(0, 15));
      stepCycle(k);
      if (k >= 0) pend[k] = 1'b0;
    end
    foreach (pend[i]) pend[i] = 1'b0;
    applyStimulus();
    bus.rsv = 0;
    stepCycle(k);
    stepCycle(k);
    @(negedge clk);
    #1;
    checkOutput("queue_drain", gntQ.size() + wbQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file's single write port. Three producers (ALU, memory load, multiply/divide unit) request the port. The block grants one per cycle, registers the winning write onto the `RegWrite`/`regW`/`Wdat` inputs of `RegFile`, and tracks pending destination registers. Issue logic uses its hazard outputs to stall dependent reads.

## Interface
- `DW`, 32, write data width.
- `AW`, 5, register index width; the scoreboard holds 2^AW busy bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req0` / `req1` / `req2`  in  1  write request from ALU / MEM / MDU.
- `reg0` / `reg1` / `reg2`  in  AW  destination register of each requester.
- `dat0` / `dat1` / `dat2`  in  DW  write data of each requester.
- `gnt0` / `gnt1` / `gnt2`  out  1  grant; combinational, one-hot or zero.
- `rsv`  in  1  issue reserves a destination register.
- `rsvReg`  in  AW  register being reserved.
- `qA`, `qB`  in  AW  source registers being read (same values as `regA`/`regB` of `RegFile`).
- `hazA`, `hazB`  out  1  source has a pending write.
- `RegWrite`  out  1  write enable to `RegFile`.
- `regW`  out  AW  write address to `RegFile`.
- `Wdat`  out  DW  write data to `RegFile`.

## Operation
- **Requester contract:** hold `reqN`/`regN`/`datN` stable until the posedge at which `gntN`=1. After that edge, either drop the request or present the next write.
- **Arbitration:** exactly one grant per cycle when any `reqN`=1. Policy is set by `Configuration`.
- **Write register:** on the edge where `gntN`=1, latch `RegWrite`←(`regN`≠0), `regW`←`regN`, `Wdat`←`datN`. With no grant, `RegWrite`←0 and `regW`/`Wdat` hold.
- **Register 0:** a write to reg 0 is granted and consumed, but `RegWrite` stays 0.
- **Scoreboard bits:** `busy[AW-1:0 → 2^AW]`.
  - Set: `rsv`=1 sets `busy[rsvReg]`; ignored for `rsvReg`=0.
  - Clear: on a grant to register r, `busy[r]` clears at the same edge.
  - Collision: `rsv` and a grant on the same r at the same edge → set wins (a new producer is in flight).
  - Re-reserving an already-busy register leaves it busy. The bit is not a counter: issue logic guarantees at most one outstanding producer per register.
- **Hazard:** `hazX` = (`qX`≠0) & (`busy[qX]` | (`RegWrite` & `regW`==`qX`)). This is combinational. The second term covers the cycle before `RegFile` commits the write.

## Timing
- **Reset** (`rst`=0, asynchronous): `RegWrite`=0, `regW`=0, `Wdat`=0, all `busy`=0, RR pointer=0.
  - `gnt0..2`=0 while `rst`=0 (gated), so `hazA`/`hazB`=0.
  - A request or reservation in flight when reset asserts is dropped. Requesters must re-issue.
- **Latency:** request seen in cycle t with grant → `RegWrite`/`regW`/`Wdat` valid in cycle t+1 → `RegFile` array updated at the end of t+1.
  - Request-to-readable is 2 edges. `hazX` stays 1 through cycle t+1.
- **Throughput:** one write per cycle. Back-to-back grants to the same requester are allowed.
- **No requests:** no grant, `RegWrite`=0 next cycle. The RR pointer is unchanged.

## Configuration
- `REGFILE_WB_RR_EN`
  - **Defined:** round-robin arbitration. A 2-bit pointer `ptr` ∈ {0,1,2} names the highest-priority requester. Search order is `ptr`, `ptr`+1, `ptr`+2 mod 3. After granting k, `ptr`←(k+1) mod 3. Any requester waits at most 2 cycles.
  - **Undefined:** fixed priority `req0` > `req1` > `req2`. No pointer state exists; `req2` may starve.

## Test plan
- **Reset:** assert `rst`=0 mid-transfer with `req1`=1 and `busy[5]`=1 → all outputs 0 immediately, `busy`=0. After release with `req1` held: `gnt1`=1 in the first cycle, `RegWrite`=1, `regW`=`reg1` the next cycle.
- **Single write:** `req0`, `reg0`=7, `dat0`=32'hDEADBEEF for one cycle → `gnt0`=1 in cycle t. In t+1: `RegWrite`=1, `regW`=7, `Wdat`=32'hDEADBEEF. In t+2: `RegWrite`=0.
- **All three contending, held asserted for 6 cycles:**
  - RR build: grant sequence 0,1,2,0,1,2.
  - Fixed build: `gnt0` every cycle, `gnt1`/`gnt2` never.
- **Scoreboard:**
  - `rsv`, `rsvReg`=9 → `hazA`=1 for `qA`=9.
  - MEM writes reg 9 granted at cycle t → `hazA` stays 1 in t+1 and is 0 in t+2.
  - Same-edge `rsv`=9 plus grant on reg 9 → `busy[9]` remains 1.
- **Register 0:** `req2`, `reg2`=0, `dat2`=1 → `gnt2`=1, then `RegWrite`=0. `rsv` with `rsvReg`=0 → `hazA`=0 for `qA`=0.
